// File: rtl/setb_release_sequencer.sv
// Reset-release sequencer for async-set/reset flop banks: asserts SETB to all
// domains on RSTB, releases them one per GAP+1 edges, then serves soft resets.
module setb_release_sequencer #(
  parameter int unsigned NDOM        = 4,
  parameter int unsigned GAP_W       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic [GAP_W-1:0] GAP,
  input  logic [NDOM-1:0]  SOFT_REQ,
  output logic [NDOM-1:0]  SETB_OUT,
  output logic [NDOM-1:0]  SOFT_ACK,
  output logic             BUSY
);

  localparam int unsigned PTR_W = (NDOM > 1) ? $clog2(NDOM) : 1;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_RELEASE,
    ST_IDLE,
    ST_SOFT_HOLD,
    ST_SOFT_ACK
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [NDOM-1:0]        setb_q, setb_d;
  logic [NDOM-1:0]        ack_q, ack_d;
  logic                   busy_q, busy_d;
  logic [GAP_W-1:0]       cnt_q, cnt_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       idx_q, idx_d;
  logic                   sync_out;
  logic                   req_any;
  logic [PTR_W-1:0]       req_idx;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign SETB_OUT = setb_q;
  assign SOFT_ACK = ack_q;
  assign BUSY     = busy_q;

  // RSTB de-assertion synchroniser; assertion is purely asynchronous
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Fixed priority: lowest requesting domain wins
  always_comb begin
    req_any = 1'b0;
    req_idx = '0;
    for (int i = NDOM - 1; i >= 0; i--) begin
      if (SOFT_REQ[i]) begin
        req_any = 1'b1;
        req_idx = PTR_W'(i);
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= ST_RESET;
      setb_q  <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b1;
      cnt_q   <= '0;
      gap_q   <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      setb_q  <= setb_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    setb_d  = setb_q;
    ack_d   = '0;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;

    case (state_q)
      ST_RESET: begin
        busy_d = 1'b1;
        if (sync_out) begin
          setb_d[0] = 1'b1;
          gap_d     = GAP;
          cnt_d     = '0;
          ptr_d     = PTR_W'(1);
          if (NDOM == 1) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RELEASE;
          end
        end
      end

      ST_RELEASE: begin
        if (cnt_q == gap_q) begin
          setb_d[ptr_q] = 1'b1;
          cnt_d         = '0;
          ptr_d         = ptr_q + PTR_W'(1);
          if (ptr_q == PTR_W'(NDOM - 1)) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + GAP_W'(1);
        end
      end

      ST_IDLE: begin
        if (req_any) begin
          setb_d[req_idx] = 1'b0;
          idx_d           = req_idx;
          busy_d          = 1'b1;
          gap_d           = GAP;
          cnt_d           = '0;
          state_d         = ST_SOFT_HOLD;
        end
      end

      ST_SOFT_HOLD: begin
        if (cnt_q == gap_q) begin
          setb_d[idx_q] = 1'b1;
          ack_d[idx_q]  = 1'b1;
          state_d       = ST_SOFT_ACK;
        end else begin
          cnt_d = cnt_q + GAP_W'(1);
        end
      end

      ST_SOFT_ACK: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

endmodule
